multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_iter_counter.sv | 23 ++
 rtl/multdiv_ctrl.sv | 107 ++++++++++
 tb/tb_multdiv_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and iteration constants for the multiply/divide controller
package multdiv_pkg;

    localparam int ITERATIONS = 32;
    localparam int ITER_W     = 5;

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_iter_counter.sv
// rtl/multdiv_iter_counter.sv - iteration counter with clear, enable and terminal count
module multdiv_iter_counter
    import multdiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [ITER_W-1:0] count,
    output logic              terminal
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == ITER_LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencing FSM for a 32-iteration multiply/divide unit
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [4:0]        dest_reg,
    input  logic              divisor_zero,
    input  logic              mult_ovf,
    input  logic              wb_ack,
    output logic              dp_load,
    output logic              dp_step,
    output logic              dp_is_div,
    output logic [ITER_W-1:0] iter,
    output logic              stall,
    output logic              result_ready,
    output logic              result_exception,
    output logic [4:0]        wb_reg
);

    state_t      state;
    state_t      state_next;
    logic        is_div_q;
    logic        exc_q;
    logic [4:0]  wb_reg_q;
    logic        any_start;
    logic        latch_op;
    logic        set_exc;
    logic        terminal;

    assign any_start = start_mult | start_div;

    multdiv_iter_counter u_iter (
        .clock    (clock),
        .reset    (reset),
        .clear    (state == ST_LOAD),
        .enable   ((state == ST_RUN) && !terminal),
        .count    (iter),
        .terminal (terminal)
    );

    always_comb begin
        state_next = state;
        latch_op   = 1'b0;
        set_exc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_start) begin
                    latch_op   = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (is_div_q && divisor_zero) begin
                    set_exc    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (terminal) begin
                    set_exc    = !is_div_q && mult_ovf;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
            wb_reg_q <= '0;
        end else begin
            state <= state_next;
            if (latch_op) begin
                // multiply wins when both starts arrive together
                is_div_q <= !start_mult;
                wb_reg_q <= dest_reg;
                exc_q    <= 1'b0;
            end
            if (set_exc) begin
                exc_q <= 1'b1;
            end
        end
    end

    assign dp_load          = (state == ST_LOAD);
    assign dp_step          = (state == ST_RUN);
    assign dp_is_div        = is_div_q;
    assign result_ready     = (state == ST_DONE);
    assign result_exception = (state == ST_DONE) && exc_q;
    assign wb_reg           = wb_reg_q;
    // a start under reset is discarded, so it must not freeze the front end
    assign stall            = (state != ST_IDLE) || (!reset && any_start);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_mult;
    logic       start_div;
    logic [4:0] dest_reg;
    logic       divisor_zero;
    logic       mult_ovf;
    logic       wb_ack;
    logic       dp_load;
    logic       dp_step;
    logic       dp_is_div;
    logic [4:0] iter;
    logic       stall;
    logic       result_ready;
    logic       result_exception;
    logic [4:0] wb_reg;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .start_mult       (start_mult),
        .start_div        (start_div),
        .dest_reg         (dest_reg),
        .divisor_zero     (divisor_zero),
        .mult_ovf         (mult_ovf),
        .wb_ack           (wb_ack),
        .dp_load          (dp_load),
        .dp_step          (dp_step),
        .dp_is_div        (dp_is_div),
        .iter             (iter),
        .stall            (stall),
        .result_ready     (result_ready),
        .result_exception (result_exception),
        .wb_reg           (wb_reg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues a start at cycle 0 and checks every cycle up to result_ready at cycle 34.
    task automatic run_op(input logic m, input logic d, input logic [4:0] dest,
                          input logic ovf_last, input int inject,
                          input logic exp_div, input logic exp_exc);
        start_mult = m;
        start_div  = d;
        dest_reg   = dest;
        #1;
        check("stall_on_start", stall, 1);
        tick();
        start_mult = 0;
        start_div  = 0;
        dest_reg   = ~dest;
        check("load_c1", dp_load, 1);
        check("no_step_c1", dp_step, 0);
        check("is_div_c1", dp_is_div, exp_div);
        for (int c = 2; c <= 33; c++) begin
            tick();
            start_div = 0;
            mult_ovf  = 0;
            if (c == inject) begin
                start_div = 1;
                mult_ovf  = 1;
            end
            if (c == 33 && ovf_last) mult_ovf = 1;
            check("step_run", dp_step, 1);
            check("no_load_run", dp_load, 0);
            check("iter_run", iter, 32'(c - 2));
            check("not_ready_run", result_ready, 0);
            check("is_div_run", dp_is_div, exp_div);
        end
        tick();
        start_div = 0;
        mult_ovf  = 0;
        check("ready_c34", result_ready, 1);
        check("wb_reg_c34", wb_reg, dest);
        check("exc_c34", result_exception, exp_exc);
        check("iter_hold_31", iter, 31);
        check("no_step_done", dp_step, 0);
        check("is_div_done", dp_is_div, exp_div);
    endtask

    task automatic ack_and_idle();
        wb_ack = 1;
        #1;
        check("stall_during_ack", stall, 1);
        tick();
        wb_ack = 0;
        #1;
        check("idle_ready", result_ready, 0);
        check("idle_stall", stall, 0);
    endtask

    initial begin
        reset = 1; start_mult = 0; start_div = 0; dest_reg = 0;
        divisor_zero = 0; mult_ovf = 0; wb_ack = 0;
        tick();
        tick();
        check("rst_load", dp_load, 0);
        check("rst_step", dp_step, 0);
        check("rst_iter", iter, 0);
        check("rst_stall", stall, 0);
        check("rst_ready", result_ready, 0);
        check("rst_exc", result_exception, 0);
        check("rst_wb_reg", wb_reg, 0);
        check("rst_is_div", dp_is_div, 0);
        reset = 0;
        tick();

        // plain multiply to r7
        run_op(1, 0, 5'd7, 0, -1, 0, 0);
        ack_and_idle();

        // divide by zero to r3: exception at cycle 2
        divisor_zero = 1;
        start_div = 1;
        dest_reg  = 5'd3;
        tick();
        start_div = 0;
        check("dz_load", dp_load, 1);
        check("dz_is_div", dp_is_div, 1);
        tick();
        divisor_zero = 0;
        check("dz_ready", result_ready, 1);
        check("dz_exc", result_exception, 1);
        check("dz_no_step", dp_step, 0);
        check("dz_wb_reg", wb_reg, 3);
        ack_and_idle();

        // multiply overflow on last iteration with writeback backpressure
        run_op(1, 0, 5'd12, 1, -1, 0, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start_mult = 1;
            tick();
            start_mult = 0;
            check("bp_ready", result_ready, 1);
            check("bp_wb_reg", wb_reg, 12);
            check("bp_exc", result_exception, 1);
            check("bp_stall", stall, 1);
        end
        ack_and_idle();

        // simultaneous starts pick multiply; mid-run start_div and stray ovf are ignored
        run_op(1, 1, 5'd20, 0, 10, 0, 0);
        ack_and_idle();

        // reset mid-run at iter=15 beats a same-cycle start and ack
        start_div = 1;
        dest_reg  = 5'd5;
        tick();
        start_div = 0;
        for (int k = 0; k < 16; k++) tick();
        check("pre_rst_iter", iter, 15);
        reset = 1; start_mult = 1; wb_ack = 1;
        tick();
        reset = 0; start_mult = 0; wb_ack = 0;
        #1;
        check("mid_rst_step", dp_step, 0);
        check("mid_rst_iter", iter, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_ready", result_ready, 0);
        check("mid_rst_wb_reg", wb_reg, 0);
        check("mid_rst_is_div", dp_is_div, 0);
        tick();
        run_op(0, 1, 5'd9, 0, -1, 1, 0);
        ack_and_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
